// File: rtl/minterm_lut_gate.sv
// rtl/minterm_lut_gate.sv - runtime-programmable sum-of-minterms evaluator with AND gate
// Optional hit counter enabled by macro MINTERM_LUT_HITCNT_EN.
module minterm_lut_gate #(
   parameter int                       N_IN       = 3,
   parameter logic [(1<<N_IN)-1:0]     RESET_MASK = 8'hD5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in_vec,
   input  logic            in_gate,
   output logic            out_valid,
   output logic            out_f,
   output logic            out_g,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_busy,
   output logic            cfg_done,
   output logic [15:0]     hit_cnt
);

   localparam int MW = 1 << N_IN;
   localparam int CW = N_IN + 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t          state_q, state_d;
   logic [MW-1:0]   mask_q, mask_d;
   logic [MW-1:0]   shadow_q, shadow_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;
   logic            out_f_q, out_f_d;
   logic            out_g_q, out_g_d;

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (cfg_valid) begin
               shadow_d = {shadow_q[MW-2:0], cfg_bit};
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(MW - 1)) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            // Whole-mask swap in one edge keeps every evaluation on a single mask.
            mask_d  = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = in_valid;
      out_f_d     = out_f_q;
      out_g_d     = out_g_q;
      if (in_valid) begin
         out_f_d = mask_q[in_vec];
         out_g_d = mask_q[in_vec] & in_gate;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mask_q      <= RESET_MASK;
         shadow_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_f_q     <= 1'b0;
         out_g_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_f_q     <= out_f_d;
         out_g_q     <= out_g_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_f     = out_f_q;
   assign out_g     = out_g_q;
   assign cfg_busy  = (state_q != IDLE);
   assign cfg_done  = (state_q == COMMIT);

`ifdef MINTERM_LUT_HITCNT_EN
   logic [15:0] hit_q, hit_d;

   always_comb begin
      hit_d = hit_q;
      if (out_valid_q && out_f_q && (hit_q != 16'hFFFF)) begin
         hit_d = hit_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q <= 16'h0000;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign hit_cnt = hit_q;
`else
   assign hit_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_minterm_lut_gate.sv
// tb/tb_minterm_lut_gate.sv - self-checking bench for minterm_lut_gate
// Reference model: active mask plus a queue of received serial bits.
module tb_minterm_lut_gate;

   localparam int N  = 3;
   localparam int MW = 8;
   localparam logic [7:0] RST_MASK = 8'hD5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  in_vec = '0;
   logic          in_gate = 1'b0;
   logic          out_valid, out_f, out_g;
   logic          cfg_start = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_bit = 1'b0;
   logic          cfg_busy, cfg_done;
   logic [15:0]   hit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   logic [7:0] m_mask;
   bit         m_q[$];
   int         m_phase;      // 0 idle, 1 collecting bits, 2 commit cycle
   logic       exp_valid, exp_f, exp_g;
   logic [15:0] exp_hit;

   minterm_lut_gate dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_vec(in_vec), .in_gate(in_gate),
      .out_valid(out_valid), .out_f(out_f), .out_g(out_g),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mask = RST_MASK;
      m_q.delete();
      m_phase = 0;
      exp_valid = 0; exp_f = 0; exp_g = 0;
      exp_hit = 16'h0;
   endtask

   // Drive one cycle of inputs, advance the model, wait for the edge, settle.
   task automatic step(input bit iv, input int vec, input bit gate,
                       input bit cs, input bit cv, input bit cb);
      in_valid = iv; in_vec = vec[N-1:0]; in_gate = gate;
      cfg_start = cs; cfg_valid = cv; cfg_bit = cb;
`ifdef MINTERM_LUT_HITCNT_EN
      if (exp_valid && exp_f && exp_hit != 16'hFFFF) exp_hit = exp_hit + 16'd1;
`endif
      exp_valid = iv;
      if (iv) begin
         exp_f = m_mask[vec];
         exp_g = m_mask[vec] & gate;
      end
      if (m_phase == 2) begin
         for (int i = 0; i < MW; i++) m_mask[MW-1-i] = m_q[i];
         m_phase = 0;
      end else if (m_phase == 1) begin
         if (cv) begin
            m_q.push_back(cb);
            if (m_q.size() == MW) m_phase = 2;
         end
      end else if (cs) begin
         m_q.delete();
         m_phase = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      in_valid = 0; cfg_start = 0; cfg_valid = 0; cfg_bit = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (out_valid !== 0 || out_f !== 0 || out_g !== 0) begin
         n_fail++; $display("FAIL reset_out: got v=%b f=%b g=%b want 0,0,0", out_valid, out_f, out_g);
      end
      n_tests++;
      if (cfg_busy !== 0 || cfg_done !== 0 || hit_cnt !== 16'h0) begin
         n_fail++; $display("FAIL reset_cfg: got busy=%b done=%b hit=%h want 0,0,0000", cfg_busy, cfg_done, hit_cnt);
      end
   endtask

   task automatic test_sweep_gate1();
      logic [7:0] tbl;
      tbl = 8'hD5;
      for (int v = 0; v < 8; v++) begin
         step(1, v, 1, 0, 0, 0);
         n_tests++;
         if (out_valid !== 1 || out_f !== tbl[v] || out_g !== tbl[v]) begin
            n_fail++; $display("FAIL sweep_g1[%0d]: got v=%b f=%b g=%b want 1,%b,%b", v, out_valid, out_f, out_g, tbl[v], tbl[v]);
         end
      end
   endtask

   task automatic test_sweep_gate0_hold();
      logic hold_f;
      for (int v = 0; v < 8; v++) begin
         step(1, v, 0, 0, 0, 0);
         n_tests++;
         if (out_f !== exp_f || out_g !== 1'b0) begin
            n_fail++; $display("FAIL sweep_g0[%0d]: got f=%b g=%b want %b,0", v, out_f, out_g, exp_f);
         end
      end
      hold_f = exp_f;
      for (int k = 0; k < 3; k++) begin
         step(0, $urandom_range(0, 7), 1, 0, 0, 0);
         n_tests++;
         if (out_valid !== 0 || out_f !== hold_f || out_g !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold[%0d]: got v=%b f=%b g=%b want 0,%b,0", k, out_valid, out_f, out_g, hold_f);
         end
      end
   endtask

   task automatic test_load_xor();
      logic [7:0] bits;
      bits = 8'b1001_0110;
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 1, bits[7-i]);
         n_tests++;
         if (cfg_busy !== 1 || cfg_done !== (i == 7)) begin
            n_fail++; $display("FAIL xor_load[%0d]: got busy=%b done=%b want 1,%b", i, cfg_busy, cfg_done, (i == 7));
         end
      end
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (cfg_busy !== 0 || cfg_done !== 0) begin
         n_fail++; $display("FAIL xor_idle: got busy=%b done=%b want 0,0", cfg_busy, cfg_done);
      end
      for (int v = 0; v < 8; v++) begin
         step(1, v, 1, 0, 0, 0);
         n_tests++;
         if (out_f !== ^v[2:0] || out_g !== ^v[2:0]) begin
            n_fail++; $display("FAIL xor_eval[%0d]: got f=%b g=%b want %b", v, out_f, out_g, ^v[2:0]);
         end
      end
   endtask

   task automatic test_load_during_sweep(input int cycles, input bit hold_start);
      for (int c = 0; c < cycles; c++) begin
         step(1, $urandom_range(0, 7), $urandom_range(0, 1),
              hold_start ? 1'b1 : (c == 0 ? 1'b1 : 1'($urandom_range(0, 1))),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         n_tests++;
         if (out_valid !== exp_valid || out_f !== exp_f || out_g !== exp_g) begin
            n_fail++; $display("FAIL live_eval[%0d]: got v=%b f=%b g=%b want %b,%b,%b", c, out_valid, out_f, out_g, exp_valid, exp_f, exp_g);
         end
         n_tests++;
         if (cfg_busy !== (m_phase != 0) || cfg_done !== (m_phase == 2) || hit_cnt !== exp_hit) begin
            n_fail++; $display("FAIL live_cfg[%0d]: got busy=%b done=%b hit=%0d want %b,%b,%0d", c, cfg_busy, cfg_done, hit_cnt, (m_phase != 0), (m_phase == 2), exp_hit);
         end
      end
   endtask

   task automatic test_reset_midload();
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(1, i, 1, 0, 1, 1'($urandom_range(0, 1)));
      rst_n = 0;
      #1;
      n_tests++;
      if (cfg_busy !== 0 || out_valid !== 0 || out_f !== 0) begin
         n_fail++; $display("FAIL async_reset: got busy=%b v=%b f=%b want 0,0,0", cfg_busy, out_valid, out_f);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 16; c++) begin
         step(1, c % 8, 1, 0, 1, 1'($urandom_range(0, 1)));
         n_tests++;
         if (out_f !== RST_MASK[c % 8] || cfg_busy !== 0) begin
            n_fail++; $display("FAIL post_reset[%0d]: got f=%b busy=%b want %b,0", c, out_f, cfg_busy, RST_MASK[c % 8]);
         end
      end
   endtask

   task automatic test_hitcnt();
      do_reset();
`ifdef MINTERM_LUT_HITCNT_EN
      for (int v = 0; v < 10; v++) step(1, v % 8, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (hit_cnt !== 16'd6 || exp_hit !== 16'd6) begin
         n_fail++; $display("FAIL hit_sweep: got %0d model %0d want 6", hit_cnt, exp_hit);
      end
      for (int c = 0; c < 65540; c++) step(1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (hit_cnt !== 16'hFFFF) begin
         n_fail++; $display("FAIL hit_sat: got %h want ffff", hit_cnt);
      end
`else
      for (int c = 0; c < 20; c++) begin
         step(1, 0, 1, 0, 0, 0);
         n_tests++;
         if (hit_cnt !== 16'h0) begin
            n_fail++; $display("FAIL hit_tied[%0d]: got %h want 0000", c, hit_cnt);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_sweep_gate1();
      test_sweep_gate0_hold();
      test_load_xor();
      test_load_during_sweep(60, 1'b0);
      test_load_during_sweep(40, 1'b1);
      test_reset_midload();
      test_hitcnt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/minterm_lut_gate.md
# minterm_lut_gate

Runtime-programmable sum-of-minterms evaluator: an N_IN-input Boolean function held as a 2^N_IN-bit minterm mask, evaluated on a registered one-cycle pipeline and AND-gated by an enable input. The mask reloads serially without stalling evaluation and switches atomically. It generalises the fixed 3-input truth-table primitive plus AND-gate circuit in the Chapter 3 combinational set, and is the reusable function-generator block for later sequential exercises.

## Interface
Parameters:
- N_IN, 3, number of function inputs (1..6); mask width MW = 2^N_IN
- RESET_MASK, 8'hD5, mask loaded at reset; bit k = f(minterm k). Default = SUM(0,2,4,6,7)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  evaluate in_vec this cycle
- in_vec  input  N_IN  function inputs; in_vec[N_IN-1] is MSB of minterm index
- in_gate  input  1  enable ANDed with function value
- out_valid  output  1  out_f/out_g valid
- out_f  output  1  registered mask[in_vec]
- out_g  output  1  registered mask[in_vec] & in_gate
- cfg_start  input  1  begin serial mask load (honoured in IDLE only)
- cfg_valid  input  1  cfg_bit valid this cycle
- cfg_bit  input  1  serial mask bit, highest minterm first
- cfg_busy  output  1  load in progress (state != IDLE)
- cfg_done  output  1  one-cycle pulse, state COMMIT
- hit_cnt  output  16  count of out_valid cycles with out_f=1 (see Configuration)

## Operation
- Active mask register `mask` (MW bits) drives evaluation; shadow register `shadow` collects serial bits; bit counter `cnt` is N_IN+1 bits wide.
- Evaluation: each clock, out_valid <= in_valid; if in_valid, out_f <= mask[in_vec], out_g <= mask[in_vec] & in_gate; if !in_valid, out_f/out_g hold.
- Evaluation never stalls; no ready signal; in_valid accepted every cycle, including during load.
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE: cfg_start=1 -> LOAD, cnt <= 0. Otherwise stay.
  - LOAD: on each cycle with cfg_valid=1, shadow <= {shadow[MW-2:0], cfg_bit}, cnt <= cnt+1. Accepting the MW-th bit -> COMMIT. cfg_valid=0 cycles stall without penalty. cfg_start ignored.
  - COMMIT: one cycle; cfg_done=1; mask <= shadow at the edge ending COMMIT; -> IDLE.
- First bit loaded ends up at mask[MW-1]; last bit at mask[0].
- Mask switch is atomic: no evaluation ever mixes old and new bits.
- cfg_bit/cfg_valid outside LOAD ignored.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_f=0, out_g=0, cfg_busy=0, cfg_done=0, hit_cnt=0, mask=RESET_MASK, shadow=0, cnt=0, state IDLE.
- Evaluation latency: 1 cycle (in_valid at edge t -> out_valid high after edge t).
- in_valid sampled at the edge ending COMMIT uses the old mask; from the next edge, new mask.
- Minimum load duration: 1 (cfg_start) + MW (bits) + 1 (COMMIT) cycles; cfg_busy high from the cycle after cfg_start accepted through COMMIT inclusive.
- Reset mid-load: load discarded, mask returns to RESET_MASK (not the last committed mask).
- cfg_start held high: after COMMIT->IDLE, a new load starts next cycle.

## Configuration
- Macro MINTERM_LUT_HITCNT_EN.
- Defined: hit_cnt increments on every cycle where out_valid=1 and out_f=1 (counted at the edge after the output register updates), saturates at 16'hFFFF, cleared only by reset.
- Undefined: counter logic omitted; hit_cnt tied to 16'h0000. Port list unchanged.

## Test plan
- Reset, then in_valid=1, in_gate=1, in_vec sweep 0..7 -> out_f sequence 1,0,1,0,1,0,1,1 one cycle delayed; out_g identical; out_valid high 8 cycles.
- Same sweep with in_gate=0 -> out_f 1,0,1,0,1,0,1,1, out_g all 0; in_valid=0 cycles -> out_valid=0, out_f/out_g held.
- cfg_start, then bits 1,0,0,1,0,1,1,0 (mask 8'h96, 3-input XOR) on consecutive cycles -> cfg_done pulses the cycle after 8th bit; subsequent sweep gives 0,1,1,0,1,0,0,1.
- Continuous sweep during a load with cfg_valid gaps (bits spread over 15 cycles) -> all results before COMMIT's closing edge match 8'hD5, all after match 8'h96; cfg_busy high throughout load.
- Assert rst_n=0 after 4 loaded bits -> cfg_busy=0 immediately, sweep matches 8'hD5; cfg_bit toggling in IDLE has no effect.
- With MINTERM_LUT_HITCNT_EN: sweep 0..7 then 0,1 -> hit_cnt=6; force long all-hit stream -> hit_cnt saturates at 16'hFFFF. Without macro: hit_cnt=0 throughout.
